// File: rtl/ingress_stream_arbiter.sv
// rtl/ingress_stream_arbiter.sv - round-robin burst arbiter merging NUM_CH ingress streams
// Grants one source for BURST_LEN beats, tags beats with the source id, marks the last beat.
module ingress_stream_arbiter #(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        chan_mask,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          m_tid,
  output logic                     busy,
  output logic [ID_W-1:0]          cur_chan,
  output logic [31:0]              burst_count
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_cur_chan;
  logic [ID_W-1:0]    r_last_grant;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [31:0]        r_burst_count;

  logic [NUM_CH-1:0]  w_req;
  logic [ID_W-1:0]    w_pick;
  logic               w_pick_vld;
  logic               w_start;
  logic               w_hs;
  logic               w_last;

  assign w_req = s_tvalid & chan_mask;

  // Search upward from the channel after the previous winner, wrapping at NUM_CH.
  always_comb begin
    int idx;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_CH;
      if (!w_pick_vld && w_req[idx]) begin
        w_pick     = ID_W'(idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_start = (r_state == ST_IDLE) && enable && w_pick_vld;

  always_comb begin
    w_state_nxt = r_state;
    s_tready    = '0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    w_hs        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        m_tdata              = s_tdata[int'(r_cur_chan)*DATA_W +: DATA_W];
        m_tvalid             = s_tvalid[r_cur_chan];
        s_tready[r_cur_chan] = m_tready;
        w_last               = (r_beat_cnt == LAST_BEAT);
        m_tlast              = w_last;
        w_hs                 = s_tvalid[r_cur_chan] && m_tready;
        if (w_hs && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_chan    <= '0;
      r_last_grant  <= ID_W'(NUM_CH - 1);
      r_beat_cnt    <= '0;
      r_burst_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cur_chan   <= w_pick;
        r_last_grant <= w_pick;
        r_beat_cnt   <= '0;
      end else if (w_hs) begin
        if (w_last) begin
          r_beat_cnt    <= '0;
          r_burst_count <= r_burst_count + 32'd1;
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign m_tid       = r_cur_chan;
  assign cur_chan    = r_cur_chan;
  assign busy        = (r_state == ST_GRANT);
  assign burst_count = r_burst_count;

endmodule

// File: tb/tb_ingress_stream_arbiter.sv
// tb/tb_ingress_stream_arbiter.sv - directed self-checking bench for ingress_stream_arbiter
// Sources emit (c<<28)|(n<<16)|n where n counts beats accepted from channel c.
module tb_ingress_stream_arbiter;
  localparam int DATA_W    = 32;
  localparam int NUM_CH    = 4;
  localparam int BURST_LEN = 16;
  localparam int ID_W      = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b0;
  logic [NUM_CH-1:0]        chan_mask = '0;
  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH-1:0]        s_tvalid = '0;
  logic [NUM_CH-1:0]        s_tready;
  logic [DATA_W-1:0]        m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic [ID_W-1:0]          m_tid;
  logic                     busy;
  logic [ID_W-1:0]          cur_chan;
  logic [31:0]              burst_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt [NUM_CH];
  bit rand_ready = 1'b0;

  ingress_stream_arbiter #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .BURST_LEN(BURST_LEN), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tid(m_tid), .busy(busy), .cur_chan(cur_chan),
    .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beat_data(input int c, input int n);
    return (32'(c) << 28) | (32'(n) << 16) | 32'(n);
  endfunction

  // Source model: advance a channel's counter after each accepted beat.
  initial begin
    logic [NUM_CH-1:0] hs;
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    for (int c = 0; c < NUM_CH; c++) s_tdata[c*DATA_W +: DATA_W] = beat_data(c, 0);
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) if (hs[c]) cnt[c] = cnt[c] + 1;
      for (int c = 0; c < NUM_CH; c++) s_tdata[c*DATA_W +: DATA_W] = beat_data(c, cnt[c]);
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // Observes one burst; act 1 drops enable, 2 stalls the source 20 cycles, 3 resets, after beat act_beat.
  task automatic collect_burst(input int act, input int act_beat, output int chan, output int beats,
                               output int errs, output int lat, output logic [NUM_CH-1:0] rdy_seen,
                               output logic bubble_busy, output logic [31:0] bc_after);
    int waitc;
    bit stalled, have_acc, done;
    logic [31:0] pd, prev_acc;
    logic pv, pl;
    chan = -1; beats = 0; errs = 0; lat = 0; rdy_seen = '0; bubble_busy = 1'b1; bc_after = '0;
    stalled = 0; have_acc = 0; done = 0; pd = '0; pv = 0; pl = 0; prev_acc = '0;
    waitc = 0;
    do begin @(negedge clk); waitc++; end while (!busy && waitc < 200);
    lat = waitc;
    if (!busy) return;
    chan = int'(cur_chan);
    waitc = 0;
    while (!done && waitc < 2000) begin
      rdy_seen = rdy_seen | s_tready;
      if ((s_tready & ~(NUM_CH'(1) << chan)) != '0) errs++;
      if (m_tid !== ID_W'(chan)) errs++;
      if (stalled && (m_tdata !== pd || m_tvalid !== pv || m_tlast !== pl)) errs++;
      stalled = m_tvalid && !m_tready; pd = m_tdata; pv = m_tvalid; pl = m_tlast;
      if (m_tvalid && m_tready) begin
        beats++;
        if (m_tdata !== beat_data(chan, cnt[chan])) errs++;
        if (have_acc && m_tdata !== prev_acc + 32'h0001_0001) errs++;
        prev_acc = m_tdata; have_acc = 1;
        if (m_tlast !== (beats == BURST_LEN)) errs++;
        if (m_tlast) done = 1;
        if (beats == act_beat && act == 1) begin
          @(posedge clk); #1; enable = 1'b0;
        end
        if (beats == act_beat && act == 2) begin
          @(posedge clk); #1; s_tvalid[chan] = 1'b0;
          repeat (20) begin
            @(negedge clk);
            if (!busy || cur_chan !== ID_W'(chan) || m_tvalid || s_tready[chan] !== m_tready) errs++;
          end
          @(posedge clk); #1; s_tvalid[chan] = 1'b1;
          stalled = 0;
        end
        if (beats == act_beat && act == 3) begin
          @(posedge clk); #1; rst = 1'b1;
          @(posedge clk); #1; rst = 1'b0;
          return;
        end
      end
      if (!done) @(negedge clk);
      waitc++;
    end
    if (!done) errs++;
    @(negedge clk);
    bubble_busy = busy;
    bc_after = burst_count;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; chan_mask = 4'b1111; s_tvalid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL reset_s_tready: got %b want 0000", s_tready); end
    n_cmp++; if (cur_chan !== 2'd0) begin n_bad++; $display("FAIL reset_cur_chan: got %0d want 0", cur_chan); end
    n_cmp++; if (burst_count !== 32'd0) begin n_bad++; $display("FAIL reset_burst_count: got %0d want 0", burst_count); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    int ch, bt, er, lt;
    logic [NUM_CH-1:0] rs;
    logic bb;
    logic [31:0] bc;
    for (int i = 0; i < 5; i++) begin
      collect_burst(0, 0, ch, bt, er, lt, rs, bb, bc);
      n_cmp++; if (ch !== exp_ch[i]) begin n_bad++; $display("FAIL rr_chan[%0d]: got %0d want %0d", i, ch, exp_ch[i]); end
      n_cmp++; if (bt !== BURST_LEN) begin n_bad++; $display("FAIL rr_beats[%0d]: got %0d want %0d", i, bt, BURST_LEN); end
      n_cmp++; if (er !== 0) begin n_bad++; $display("FAIL rr_beat_errors[%0d]: got %0d want 0", i, er); end
      n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL rr_bubble[%0d]: busy got %b want 0", i, bb); end
      if (i > 0) begin
        n_cmp++; if (lt !== 1) begin n_bad++; $display("FAIL rr_gap[%0d]: got %0d want 1", i, lt); end
      end
      if (i == 3) begin
        n_cmp++; if (bc !== 32'd4) begin n_bad++; $display("FAIL rr_burst_count: got %0d want 4", bc); end
      end
    end
  endtask

  task automatic test_mask();
    int exp_ch [4] = '{0, 2, 0, 2};
    int ch, bt, er, lt;
    logic [NUM_CH-1:0] rs, rs_all;
    logic bb;
    logic [31:0] bc;
    rs_all = '0;
    pulse_reset();
    chan_mask = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      collect_burst(0, 0, ch, bt, er, lt, rs, bb, bc);
      rs_all = rs_all | rs;
      n_cmp++; if (ch !== exp_ch[i]) begin n_bad++; $display("FAIL mask_chan[%0d]: got %0d want %0d", i, ch, exp_ch[i]); end
      n_cmp++; if (bt !== BURST_LEN || er !== 0) begin n_bad++; $display("FAIL mask_burst[%0d]: beats %0d errors %0d want %0d/0", i, bt, er, BURST_LEN); end
    end
    n_cmp++; if ((rs_all & 4'b1010) !== 4'b0000) begin n_bad++; $display("FAIL mask_ready_1_3: got %b want 0000", rs_all & 4'b1010); end
  endtask

  task automatic test_backpressure();
    int ch, bt, er, lt;
    logic [NUM_CH-1:0] rs;
    logic bb;
    logic [31:0] bc;
    pulse_reset();
    chan_mask = 4'b1111; s_tvalid = 4'b0010; rand_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      collect_burst(0, 0, ch, bt, er, lt, rs, bb, bc);
      n_cmp++; if (ch !== 1) begin n_bad++; $display("FAIL bp_chan[%0d]: got %0d want 1", i, ch); end
      n_cmp++; if (bt !== BURST_LEN) begin n_bad++; $display("FAIL bp_beats[%0d]: got %0d want %0d", i, bt, BURST_LEN); end
      n_cmp++; if (er !== 0) begin n_bad++; $display("FAIL bp_hold_or_data[%0d]: got %0d errors want 0", i, er); end
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_enable_drop();
    int ch, bt, er, lt, busy_cycles;
    logic [NUM_CH-1:0] rs;
    logic bb;
    logic [31:0] bc;
    pulse_reset();
    chan_mask = 4'b0100; s_tvalid = 4'b1111;
    collect_burst(1, 5, ch, bt, er, lt, rs, bb, bc);
    n_cmp++; if (ch !== 2) begin n_bad++; $display("FAIL en_chan: got %0d want 2", ch); end
    n_cmp++; if (bt !== BURST_LEN) begin n_bad++; $display("FAIL en_beats: got %0d want %0d", bt, BURST_LEN); end
    n_cmp++; if (er !== 0) begin n_bad++; $display("FAIL en_beat_errors: got %0d want 0", er); end
    busy_cycles = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || m_tvalid) busy_cycles++;
    end
    n_cmp++; if (busy_cycles !== 0) begin n_bad++; $display("FAIL en_idle_persist: got %0d busy cycles want 0", busy_cycles); end
    @(posedge clk); #1; enable = 1'b1; chan_mask = 4'b1111;
  endtask

  task automatic test_reset_mid();
    int ch, bt, er, lt;
    logic [NUM_CH-1:0] rs;
    logic bb;
    logic [31:0] bc;
    pulse_reset();
    chan_mask = 4'b1111; s_tvalid = 4'b1111; enable = 1'b1;
    collect_burst(3, 8, ch, bt, er, lt, rs, bb, bc);
    n_cmp++; if (ch !== 0 || bt !== 8) begin n_bad++; $display("FAIL rstmid_pre: chan %0d beats %0d want 0/8", ch, bt); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_bad++; $display("FAIL rstmid_tvalid_tlast: got %b%b want 00", m_tvalid, m_tlast); end
    n_cmp++; if (burst_count !== 32'd0) begin n_bad++; $display("FAIL rstmid_burst_count: got %0d want 0", burst_count); end
    collect_burst(0, 0, ch, bt, er, lt, rs, bb, bc);
    n_cmp++; if (ch !== 0) begin n_bad++; $display("FAIL rstmid_next_chan: got %0d want 0", ch); end
    n_cmp++; if (bt !== BURST_LEN || er !== 0) begin n_bad++; $display("FAIL rstmid_next_burst: beats %0d errors %0d want %0d/0", bt, er, BURST_LEN); end
    n_cmp++; if (bc !== 32'd1) begin n_bad++; $display("FAIL rstmid_count_after: got %0d want 1", bc); end
  endtask

  task automatic test_source_stall();
    int ch, bt, er, lt;
    logic [NUM_CH-1:0] rs;
    logic bb;
    logic [31:0] bc;
    pulse_reset();
    chan_mask = 4'b1111; s_tvalid = 4'b1111; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      collect_burst(0, 0, ch, bt, er, lt, rs, bb, bc);
      n_cmp++; if (ch !== i) begin n_bad++; $display("FAIL stall_pre_chan[%0d]: got %0d want %0d", i, ch, i); end
    end
    collect_burst(2, 10, ch, bt, er, lt, rs, bb, bc);
    n_cmp++; if (ch !== 3) begin n_bad++; $display("FAIL stall_chan: got %0d want 3", ch); end
    n_cmp++; if (bt !== BURST_LEN) begin n_bad++; $display("FAIL stall_beats: got %0d want %0d", bt, BURST_LEN); end
    n_cmp++; if (er !== 0) begin n_bad++; $display("FAIL stall_hold_grant: got %0d errors want 0", er); end
    n_cmp++; if (bc !== 32'd4) begin n_bad++; $display("FAIL stall_burst_count: got %0d want 4", bc); end
    collect_burst(0, 0, ch, bt, er, lt, rs, bb, bc);
    n_cmp++; if (ch !== 0) begin n_bad++; $display("FAIL stall_next_chan: got %0d want 0", ch); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_source_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
